// File: rtl/mdu_param_if.sv
// Bundle between the E-stage pipeline (master) and the multiply/divide unit (slave).
interface mdu_param_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       op;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_hazard;

    modport master (
        output op, start, abort, a, b,
        input  busy, hi, lo, md_hazard
    );

    modport slave (
        input  op, start, abort, a, b,
        output busy, hi, lo, md_hazard
    );
endinterface

// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit owning HI/LO; results are computed from the
// operands latched at launch and committed after a fixed latency.
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_param_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam int W2         = 2 * WIDTH;

    logic [0:0]       state;
    logic [CW-1:0]    counter;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             launchable;
    logic             is_div_op;

    always_comb begin
        launchable = 1'b0;
        case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: launchable = 1'b1;
            default: launchable = 1'b0;
        endcase
    end

    assign is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);

    // Products: sign/zero extension to 2*WIDTH makes the truncated product exact.
    logic [W2-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc;
    assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign a_zx   = {{WIDTH{1'b0}}, a_q};
    assign b_zx   = {{WIDTH{1'b0}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign acc    = {hi_q, lo_q};

    // Signed divide via magnitudes; most-negative / -1 falls out naturally as MIN, rem 0.
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, bu_div, bs_div;
    logic [WIDTH-1:0] sq_mag, sr_mag, div_q, div_r, divu_q, divu_r;
    assign a_neg  = a_q[WIDTH-1];
    assign b_neg  = b_q[WIDTH-1];
    assign b_zero = (b_q == '0);
    assign a_mag  = a_neg ? (WIDTH'(0) - a_q) : a_q;
    assign b_mag  = b_neg ? (WIDTH'(0) - b_q) : b_q;
    assign bu_div = b_zero ? WIDTH'(1) : b_q;
    assign bs_div = b_zero ? WIDTH'(1) : b_mag;
    assign divu_q = a_q / bu_div;
    assign divu_r = a_q % bu_div;
    assign sq_mag = a_mag / bs_div;
    assign sr_mag = a_mag % bs_div;
    assign div_q  = (a_neg ^ b_neg) ? (WIDTH'(0) - sq_mag) : sq_mag;
    assign div_r  = a_neg ? (WIDTH'(0) - sr_mag) : sr_mag;

    logic [W2-1:0] commit_hilo;
    always_comb begin
        commit_hilo = acc;
        case (op_q)
            OP_MULT:  commit_hilo = prod_s;
            OP_MULTU: commit_hilo = prod_u;
            OP_DIV:   if (!b_zero) commit_hilo = {div_r, div_q};
            OP_DIVU:  if (!b_zero) commit_hilo = {divu_r, divu_q};
            OP_MADD:  commit_hilo = acc + prod_s;
            OP_MADDU: commit_hilo = acc + prod_u;
            OP_MSUB:  commit_hilo = acc - prod_s;
            OP_MSUBU: commit_hilo = acc - prod_u;
            default:  commit_hilo = acc;
        endcase
    end

    // Abort always wins, including over the commit on the final busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.abort) begin
                        if (bus.start && launchable) begin
                            op_q    <= bus.op;
                            a_q     <= bus.a;
                            b_q     <= bus.b;
                            counter <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state   <= S_RUN;
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                default: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        counter <= '0;
                    end else if (counter == CW'(1)) begin
                        {hi_q, lo_q} <= commit_hilo;
                        state        <= S_IDLE;
                        counter      <= '0;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.busy      = (state == S_RUN);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.md_hazard = bus.start | bus.busy;
endmodule

// File: tb/tb_mdu_param.sv
// Self-checking bench for mdu_param: a vector table of launches with a result
// scoreboard, followed by hand sequences for abort, ignored start and reset.
module tb_mdu_param;
    localparam int WIDTH = 32;
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } result_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    vec_t vecs [12];
    result_t scoreboard [$];

    mdu_param_if #(.WIDTH(WIDTH)) bus ();

    mdu_param #(.WIDTH(WIDTH), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        bus.op = OP_MTHI; bus.a = h; bus.start = 1'b0;
        step();
        bus.op = OP_MTLO; bus.a = l;
        step();
        bus.op = OP_NONE; bus.a = '0;
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        result_t r;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        r.hi = eh; r.lo = el;
        scoreboard.push_back(r);
        step();
        bus.start = 1'b0; bus.op = OP_NONE; bus.a = '0; bus.b = '0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int n;
        result_t r;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            step();
        end
        check_output({name, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
        if (scoreboard.size() == 0) begin
            check_output({name, "_scoreboard_empty"}, 64'(0), 64'(1));
        end else begin
            r = scoreboard.pop_front();
            check_output({name, "_hilo"}, {bus.hi, bus.lo}, {r.hi, r.lo});
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        set_hilo(v.pre_hi, v.pre_lo);
        check_output({v.name, "_pre_hilo"}, {bus.hi, bus.lo}, {v.pre_hi, v.pre_lo});
        launch(v.op, v.a, v.b, v.exp_hi, v.exp_lo);
        check_output({v.name, "_busy_after_start"}, 64'(bus.busy), 64'(1));
        wait_done(v.name, v.cycles);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        vecs[0]  = '{"mult_neg3x5",   OP_MULT,  32'hFFFFFFFD, 32'd5,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1]  = '{"divu_7_2",      OP_DIVU,  32'd7,        32'd2,        32'h0,  32'h0,        32'd1,        32'd3,        10};
        vecs[2]  = '{"div_neg7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{"div_min_neg1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,        32'h0,        32'h80000000, 10};
        vecs[4]  = '{"divu_by_zero",  OP_DIVU,  32'd9,        32'd0,        32'h11, 32'h22,       32'h11,       32'h22,       10};
        vecs[5]  = '{"maddu_1x1",     OP_MADDU, 32'd1,        32'd1,        32'h0,  32'hFFFFFFFF, 32'h1,        32'h0,        5};
        vecs[6]  = '{"msub_1x1",      OP_MSUB,  32'd1,        32'd1,        32'h1,  32'h0,        32'h0,        32'hFFFFFFFF, 5};
        vecs[7]  = '{"multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,        32'hFFFFFFFE, 32'h1,        5};
        vecs[8]  = '{"div_7_neg2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,        32'h1,        32'hFFFFFFFD, 10};
        vecs[9]  = '{"madd_neg1x2",   OP_MADD,  32'hFFFFFFFF, 32'd2,        32'h0,  32'h5,        32'h0,        32'h3,        5};
        vecs[10] = '{"msubu_wrap",    OP_MSUBU, 32'd1,        32'd1,        32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        vecs[11] = '{"div_by_zero",   OP_DIV,   32'h80000000, 32'd0,        32'h33, 32'h44,       32'h33,       32'h44,       10};

        bus.op = OP_NONE; bus.start = 1'b0; bus.abort = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        #12;
        check_output("reset_state", {31'b0, bus.busy, bus.hi, bus.lo}, 64'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
        end

        // start with non-launchable ops, and md_hazard follows start combinationally
        bus.op = OP_NONE; bus.start = 1'b1;
        #1;
        check_output("md_hazard_on_start", 64'(bus.md_hazard), 64'(1));
        step();
        check_output("start_none_no_busy", 64'(bus.busy), 64'(0));
        bus.op = 4'd12;
        step();
        check_output("start_op12_no_busy", 64'(bus.busy), 64'(0));
        bus.op = OP_MTHI; bus.a = 32'h55;
        step();
        bus.start = 1'b0; bus.op = OP_NONE;
        check_output("mthi_with_start", {31'b0, bus.busy, bus.hi}, {32'h0, 32'h55});

        // abort in busy cycle 3
        set_hilo(32'hAA, 32'hBB);
        launch(OP_MULT, 32'd3, 32'd4, 32'h0, 32'h0);
        void'(scoreboard.pop_back());
        step(); step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_output("abort_busy", 64'(bus.busy), 64'(0));
        for (int k = 0; k < 5; k++) step();
        check_output("abort_hilo_kept", {bus.hi, bus.lo}, {32'hAA, 32'hBB});

        // abort on the final busy cycle wins over commit
        launch(OP_MULT, 32'd3, 32'd4, 32'h0, 32'h0);
        void'(scoreboard.pop_back());
        for (int k = 0; k < 4; k++) step();
        check_output("abort_last_busy_before", 64'(bus.busy), 64'(1));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_output("abort_last_hilo", {31'b0, bus.busy, bus.hi, bus.lo}, {32'h0, 32'hAA, 32'hBB});

        // start and abort together in IDLE
        bus.op = OP_MULT; bus.a = 32'd7; bus.b = 32'd7; bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.op = OP_NONE; bus.start = 1'b0; bus.abort = 1'b0;
        check_output("start_abort_idle", {31'b0, bus.busy, bus.hi, bus.lo}, {32'h0, 32'hAA, 32'hBB});

        // start during RUN is ignored
        set_hilo(32'h0, 32'h0);
        launch(OP_MULT, 32'd2, 32'd3, 32'h0, 32'd6);
        bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
        step();
        bus.op = OP_NONE; bus.a = '0; bus.b = '0; bus.start = 1'b0;
        check_output("md_hazard_in_run", 64'(bus.md_hazard), 64'(1));
        wait_done("start_in_run", 4);

        // asynchronous reset in busy cycle 4 of a divide
        set_hilo(32'h12, 32'h34);
        launch(OP_DIV, 32'd100, 32'd7, 32'h0, 32'h0);
        void'(scoreboard.pop_back());
        step(); step(); step();
        #3;
        reset = 1'b1;
        #1;
        check_output("async_reset_mid_div", {31'b0, bus.busy, bus.hi, bus.lo}, 64'h0);
        reset = 1'b0;
        step();
        launch(OP_MULT, 32'd2, 32'd3, 32'h0, 32'd6);
        wait_done("mult_after_reset", 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It owns the HI/LO registers.
- Executes signed and unsigned mult/div and madd/msub over configurable latencies. Also handles mthi/mtlo.
- Exposes busy/start so the D-stage stall logic can hold md/mf/mt instructions.
- Adds three things over the fixed 32-bit unit: width and latency parameters, an abort input for pipeline flush, and defined divide-by-zero behaviour.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_CYCLES, 5: busy cycles for mult/multu/madd/maddu/msub/msubu; must be at least 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 are treated as NONE.
- start  in  1  single-cycle launch qualifier for ops 1-4 and 7-10.
- abort  in  1  flush request; cancels a launch in the same cycle and any in-flight operation.
- a  in  WIDTH  rs operand, already forwarded.
- b  in  WIDTH  rt operand, already forwarded.
- busy  out  1  high while an operation is in flight.
- hi  out  WIDTH  architectural HI, registered.
- lo  out  WIDTH  architectural LO, registered.
- md_hazard  out  1  equals start OR busy (combinational); this is the stall input for D-stage md/mf/mt.

Behaviour:
- Reset, asynchronous, at any time including mid-operation:
  - busy=0, hi=0, lo=0, counter=0, state IDLE.
  - Any pending result is discarded.
- State machine, IDLE -> RUN -> IDLE:
  - IDLE with start=1, abort=0 and a launchable op (1-4, 7-10): latch a, b and op; load counter with N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - RUN: busy=1; counter decrements each cycle.
  - RUN with counter==1: at that edge, commit the result to hi/lo and return to IDLE.
- Timing: for a start at cycle t, busy is high during cycles t+1 .. t+N. The new hi/lo is visible from cycle t+N+1, the same cycle busy falls.
- start in RUN is ignored (the stall logic guarantees it does not occur); no operand is relatched.
- start with op NONE or 5/6 does not launch and busy stays 0.
- abort:
  - In IDLE, abort suppresses a same-cycle launch.
  - In RUN, abort forces IDLE at the next edge with busy=0 and hi/lo unchanged.
  - abort takes priority over the final commit when both fall in the same cycle.
- MTHI/MTLO:
  - When op=5 or 6 in IDLE with abort=0, write hi=a or lo=a at the next edge, independent of start.
  - busy is not asserted.
  - op=5/6 while in RUN is ignored.
- Arithmetic (product P is 2*WIDTH bits; {hi,lo} = result):
  - MULT: signed product.
  - MULTU: unsigned product.
  - MADD/MSUB: {hi,lo} ± signed P, wrapping modulo 2^(2*WIDTH); the {hi,lo} used is the value at launch.
  - MADDU/MSUBU: same, using the unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Most-negative value / -1 gives lo=most-negative value and hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b==0, latched at launch):
  - The full DIV_CYCLES busy period still runs.
  - hi and lo are left unchanged at commit.
- Result computation may be combinational on the latched operands; only the commit timing above is architecturally visible.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, start at t: busy=1 for t+1..t+5; at t+6, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- DIVU a=7, b=2: busy high for 10 cycles, then lo=3, hi=1. DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - With hi=0x11, lo=0x22, DIVU by b=0 -> busy 10 cycles, then hi=0x11, lo=0x22.
- Accumulate and move: MTHI a=0, MTLO a=0xFFFFFFFF, then MADDU a=1, b=1 -> after 5 busy cycles hi=1, lo=0; then MSUB a=1, b=1 -> hi=0, lo=0xFFFFFFFF.
- Abort and ignored start:
  - MULT 3×4 started, abort asserted in busy cycle 3 -> busy=0 next cycle, hi/lo keep prior values.
  - start+abort in the same IDLE cycle -> no busy.
  - start during RUN -> ignored; the original result commits.
- Reset mid-DIV (busy cycle 4): hi=lo=0 and busy=0 immediately, asynchronously. A new MULT 2×3 after reset release gives lo=6, hi=0.
